// File: rtl/updi_cmd_gen.sv
// UPDI command generator: frames SYNCH / REPEAT / ST|LD ptr++ / data bytes into 12-bit UART frames.
// Define UPDI_CG_ACK_EN to wait for a per-element ACK from the target during ST data.
module updi_cmd_gen #(
    parameter int REP_W  = 8,
    parameter int LEN_W  = REP_W + 3,
    parameter int ACK_TO = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [1:0]       i_size,
    input  logic [REP_W-1:0] i_repeat,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [11:0]      o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [LEN_W-1:0] o_rx_len,
    input  logic             i_ack_valid,
    input  logic             i_ack_ok
);

    // Handshakes: a byte moves on either side only in a cycle where its valid and ready are both high.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_REP_OP,
        S_REP_CNT,
        S_INSTR,
        S_DATA,
        S_DONE
`ifdef UPDI_CG_ACK_EN
        , S_ACK_WAIT
`endif
    } state_t;

    function automatic logic [11:0] f_frame(input logic [7:0] b);
        return {2'b11, ^b, b, 1'b0};
    endfunction

    state_t           r_state;
    logic             r_mode;
    logic [1:0]       r_size;
    logic [REP_W-1:0] r_repeat;
    logic [11:0]      r_data;
    logic             r_valid;
    logic             r_done;
    logic             r_err;
    logic [LEN_W-1:0] r_rx_len;
    logic [LEN_W-1:0] r_byte_rem;

    logic [7:0]       w_instr;
    logic [7:0]       w_rep_byte;
    logic [LEN_W-1:0] w_elems;
    logic [LEN_W-1:0] w_len;
    logic             w_drain;
    logic             w_acc;
    logic             w_hs;

    assign w_instr    = {(r_mode ? 4'b0010 : 4'b0110), 2'b01, r_size};
    assign w_rep_byte = 8'(r_repeat);
    assign w_elems    = LEN_W'(r_repeat) + LEN_W'(1);
    assign w_len      = w_elems << r_size;
    assign w_drain    = !r_valid || i_ready;
    assign w_hs       = r_valid && i_ready;
    assign w_acc      = i_valid && o_ready;

`ifdef UPDI_CG_ACK_EN
    localparam int TO_W = $clog2(ACK_TO + 1);
    logic [TO_W-1:0] r_to;
    logic [2:0]      r_elem_rem;
    logic            r_elem_end;
    logic [2:0]      w_elem_bytes;

    assign w_elem_bytes = 3'd1 << r_size;
    // Once an element's last byte is in the register, hold off the application until the ACK.
    assign o_ready = (r_state == S_DATA) && w_drain && (r_byte_rem != '0) && !r_elem_end;
`else
    logic w_unused;

    assign w_unused = i_ack_valid ^ i_ack_ok ^ (ACK_TO == 0);
    assign o_ready  = (r_state == S_DATA) && w_drain && (r_byte_rem != '0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_size     <= 2'd0;
            r_repeat   <= '0;
            r_data     <= 12'd0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rx_len   <= '0;
            r_byte_rem <= '0;
`ifdef UPDI_CG_ACK_EN
            r_to       <= '0;
            r_elem_rem <= 3'd0;
            r_elem_end <= 1'b0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rx_len <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_size == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode   <= i_mode;
                            r_size   <= i_size;
                            r_repeat <= i_repeat;
                            r_data   <= f_frame(8'h55);
                            r_valid  <= 1'b1;
                            r_state  <= S_SYNC;
                        end
                    end
                end
                S_SYNC: begin
                    if (w_hs) begin
                        if (r_repeat == '0) begin
                            r_data  <= f_frame(w_instr);
                            r_state <= S_INSTR;
                        end else begin
                            r_data  <= f_frame(8'hA0);
                            r_state <= S_REP_OP;
                        end
                    end
                end
                S_REP_OP: begin
                    if (w_hs) begin
                        r_data  <= f_frame(w_rep_byte);
                        r_state <= S_REP_CNT;
                    end
                end
                S_REP_CNT: begin
                    if (w_hs) begin
                        r_data  <= f_frame(w_instr);
                        r_state <= S_INSTR;
                    end
                end
                S_INSTR: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (r_mode) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_rx_len <= w_len;
                        end else begin
                            r_state    <= S_DATA;
                            r_byte_rem <= w_len;
`ifdef UPDI_CG_ACK_EN
                            r_elem_rem <= w_elem_bytes;
                            r_elem_end <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_data     <= f_frame(i_data);
                        r_valid    <= 1'b1;
                        r_byte_rem <= r_byte_rem - LEN_W'(1);
`ifdef UPDI_CG_ACK_EN
                        r_elem_rem <= r_elem_rem - 3'd1;
                        if (r_elem_rem == 3'd1) begin
                            r_elem_end <= 1'b1;
                        end
`endif
                    end else if (w_hs) begin
                        r_valid <= 1'b0;
`ifdef UPDI_CG_ACK_EN
                        if (r_elem_end) begin
                            r_elem_end <= 1'b0;
                            r_to       <= '0;
                            r_state    <= S_ACK_WAIT;
                        end
`else
                        if (r_byte_rem == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef UPDI_CG_ACK_EN
                S_ACK_WAIT: begin
                    if (i_ack_valid && i_ack_ok) begin
                        r_elem_rem <= w_elem_bytes;
                        if (r_byte_rem == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else if (i_ack_valid || (r_to == TO_W'(ACK_TO - 1))) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_rx_len = r_rx_len;
    assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_updi_cmd_gen.sv
// Scoreboard bench for updi_cmd_gen: expected frames are queued by the drivers and popped by a
// monitor on every PHY handshake; done/err pulses are counted and checked per transaction.
module tb_updi_cmd_gen;

    localparam int REP_W  = 8;
    localparam int LEN_W  = 11;
    localparam int ACK_TO = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_mode;
    logic [1:0]       i_size;
    logic [REP_W-1:0] i_repeat;
    logic [7:0]       i_data;
    logic             i_valid;
    logic             o_ready;
    logic [11:0]      o_data;
    logic             o_valid;
    logic             i_ready;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [LEN_W-1:0] o_rx_len;
    logic             i_ack_valid;
    logic             i_ack_ok;

    updi_cmd_gen #(.REP_W(REP_W), .LEN_W(LEN_W), .ACK_TO(ACK_TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_mode(i_mode), .i_size(i_size),
        .i_repeat(i_repeat), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_rx_len(o_rx_len),
        .i_ack_valid(i_ack_valid), .i_ack_ok(i_ack_ok)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail = 0;
    int               done_cnt = 0;
    int               err_cnt = 0;
    int               ready_cnt = 0;
    int               n_acc = 0;
    int               d0;
    int               e0;
    logic             stall_en = 1'b0;
    logic [LEN_W-1:0] exp_rx_len = '0;
    logic [11:0]      exp_q[$];
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic             prev_hs = 1'b0;
    logic [11:0]      prev_data = 12'd0;
    int               ack_kind = 1;
    int               wait_cnt = 0;
    int               max_wait = 0;
    int               pause_at[$];

    function automatic logic [11:0] mk_frame(input logic [7:0] b);
        return {2'b11, ^b, b, 1'b0};
    endfunction

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 29 + 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PHY side: accepts every frame, or stalls pseudo-randomly when stall_en is set.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops one expected frame per PHY handshake and checks hold behaviour during stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_valid && !prev_ready) begin
                    check("stall_hold_valid", 32'(o_valid), 32'd1);
                    check("stall_hold_data", 32'(o_data), 32'(prev_data));
                end
                if (o_valid && !i_ready) begin
                    check("ready_low_in_stall", 32'(o_ready), 32'd0);
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got 0x%03h, expected no frame", o_data);
                    end else begin
                        check("frame", 32'(o_data), 32'(exp_q.pop_front()));
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    check("rx_len_at_done", 32'(o_rx_len), 32'(exp_rx_len));
`ifndef UPDI_CG_ACK_EN
                    check("done_after_last_hs", 32'(prev_hs), 32'd1);
`endif
                end
                if (o_err) err_cnt++;
                if (o_ready) ready_cnt++;
            end
            prev_valid = o_valid;
            prev_ready = i_ready;
            prev_hs    = o_valid && i_ready;
            prev_data  = o_data;
        end
    end

`ifdef UPDI_CG_ACK_EN
    // Target model: answers each ACK wait after three cycles (1 = ACK, 2 = NACK, 3 = silent).
    initial begin
        i_ack_valid = 1'b0;
        i_ack_ok    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && o_busy && !o_valid && !o_ready && !o_done) begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
                if (ack_kind != 3 && wait_cnt == 3) begin
                    pause_at.push_back(n_acc);
                    tick();
                    i_ack_valid = 1'b1;
                    i_ack_ok    = (ack_kind == 1);
                    tick();
                    i_ack_valid = 1'b0;
                    wait_cnt    = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end
`else
    initial begin
        i_ack_valid = 1'b1;
        i_ack_ok    = 1'b0;
    end
`endif

    task automatic drive_bytes(input int n);
        int cyc;
        cyc     = 0;
        n_acc   = 0;
        i_valid = (n > 0);
        i_data  = pat(0);
        while (n_acc < n && cyc < 20000) begin
            @(negedge clk);
            if (o_ready && i_valid) begin
                exp_q.push_back(mk_frame(i_data));
                n_acc++;
            end
            tick();
            cyc++;
            i_data = pat(n_acc);
            if (!o_busy) break;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (o_busy && cyc < 5000) begin
            tick();
            cyc++;
        end
        check({name, "_idle"}, 32'(o_busy), 32'd0);
        tick();
        check({name, "_rx_len_idle"}, 32'(o_rx_len), 32'd0);
    endtask

    task automatic run_txn(input string name, input logic mode, input logic [1:0] size,
                           input logic [7:0] rep, input logic [11:0] rep_f,
                           input logic [11:0] instr_f, input int nbytes, input int exp_sent,
                           input logic [LEN_W-1:0] exp_rx, input int exp_done, input int exp_err,
                           input logic timing, input logic poke);
        int r0;
        int hc;
        exp_q.push_back(12'hCAA);
        if (rep != 8'd0) begin
            exp_q.push_back(12'hD40);
            exp_q.push_back(rep_f);
        end
        exp_q.push_back(instr_f);
        hc         = (rep != 8'd0) ? 4 : 2;
        exp_rx_len = exp_rx;
        d0         = done_cnt;
        e0         = err_cnt;
        r0         = ready_cnt;
        i_mode     = mode;
        i_size     = size;
        i_repeat   = rep;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        if (timing) begin
            check({name, "_sync_valid"}, 32'(o_valid), 32'd1);
            check({name, "_sync_data"}, 32'(o_data), 32'hCAA);
            if (poke) begin
                i_start  = 1'b1;
                i_mode   = ~mode;
                i_size   = 2'd3;
                i_repeat = 8'd0;
            end
            repeat (hc - 1) tick();
            i_start = 1'b0;
            check({name, "_instr_data"}, 32'(o_data), 32'(instr_f));
        end
        drive_bytes(nbytes);
        wait_idle(name);
        check({name, "_done_cnt"}, 32'(done_cnt - d0), 32'(exp_done));
        check({name, "_err_cnt"}, 32'(err_cnt - e0), 32'(exp_err));
        check({name, "_bytes_sent"}, 32'(n_acc), 32'(exp_sent));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (mode) check({name, "_no_ready"}, 32'(ready_cnt - r0), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected the bench to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        i_start  = 1'b0;
        i_mode   = 1'b0;
        i_size   = 2'd0;
        i_repeat = '0;
        i_data   = 8'd0;
        i_valid  = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_rx_len", 32'(o_rx_len), 32'd0);
        rst = 1'b0;
        tick();

        run_txn("st_s2_r9", 1'b0, 2'd2, 8'd9, 12'hC12, 12'hCCC, 40, 40, '0, 1, 0, 1'b1, 1'b1);
        run_txn("st_s0_r0", 1'b0, 2'd0, 8'd0, 12'h000, 12'hEC8, 1, 1, '0, 1, 0, 1'b1, 1'b0);
        run_txn("ld_s0_r3", 1'b1, 2'd0, 8'd3, 12'hC06, 12'hC48, 0, 0, 11'd4, 1, 0, 1'b1, 1'b1);
        run_txn("ld_s2_r255", 1'b1, 2'd2, 8'd255, 12'hDFE, 12'hE4C, 0, 0, 11'd1024, 1, 0, 1'b1, 1'b0);
        run_txn("st_s1_r1", 1'b0, 2'd1, 8'd1, 12'hE02, 12'hCCA, 4, 4, '0, 1, 0, 1'b1, 1'b0);

        // Illegal element size: error pulse only, never leaves IDLE.
        e0       = err_cnt;
        d0       = done_cnt;
        i_size   = 2'd3;
        i_mode   = 1'b0;
        i_repeat = 8'd5;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        check("illegal_err", 32'(o_err), 32'd1);
        check("illegal_busy", 32'(o_busy), 32'd0);
        check("illegal_valid", 32'(o_valid), 32'd0);
        tick();
        check("illegal_err_pulse", 32'(o_err), 32'd0);
        check("illegal_busy_after", 32'(o_busy), 32'd0);
        check("illegal_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("illegal_done_cnt", 32'(done_cnt - d0), 32'd0);

        stall_en = 1'b1;
        run_txn("st_stall", 1'b0, 2'd2, 8'd255, 12'hDFE, 12'hCCC, 1024, 1024, '0, 1, 0, 1'b0, 1'b0);
        stall_en = 1'b0;
        tick();

        // Reset in the middle of the data phase.
        exp_q.push_back(12'hCAA);
        exp_q.push_back(12'hD40);
        exp_q.push_back(12'hE0E);
        exp_q.push_back(12'hEC8);
        i_mode   = 1'b0;
        i_size   = 2'd0;
        i_repeat = 8'd7;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        drive_bytes(3);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_data", 32'(o_data), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        check("midrst_rx_len", 32'(o_rx_len), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        run_txn("st_after_rst", 1'b0, 2'd2, 8'd9, 12'hC12, 12'hCCC, 40, 40, '0, 1, 0, 1'b1, 1'b0);

`ifdef UPDI_CG_ACK_EN
        ack_kind = 1;
        pause_at.delete();
        run_txn("ack_ok", 1'b0, 2'd1, 8'd1, 12'hE02, 12'hCCA, 4, 4, '0, 1, 0, 1'b0, 1'b0);
        check("ack_ok_pauses", 32'(pause_at.size()), 32'd2);
        if (pause_at.size() == 2) begin
            check("ack_ok_pause1", 32'(pause_at[0]), 32'd2);
            check("ack_ok_pause2", 32'(pause_at[1]), 32'd4);
        end
        ack_kind = 2;
        run_txn("ack_nack", 1'b0, 2'd1, 8'd1, 12'hE02, 12'hCCA, 4, 2, '0, 0, 1, 1'b0, 1'b0);
        ack_kind = 3;
        max_wait = 0;
        run_txn("ack_timeout", 1'b0, 2'd1, 8'd1, 12'hE02, 12'hCCA, 4, 2, '0, 0, 1, 1'b0, 1'b0);
        check("ack_timeout_cycles", 32'(max_wait), 32'(ACK_TO));
        ack_kind = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
